// File: rtl/uart_alu_ctrl.sv
// Sequencer that gathers operand A, operand B and an opcode from the UART receiver,
// runs them through the external ALU and sends the one-byte result back out.
module uart_alu_ctrl #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int NB_TIMEOUT     = 24,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx_done_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_tx_done_tick,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_error,
  output logic               o_overrun
);

  typedef enum logic [2:0] {
    WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX
  } state_t;

  localparam logic [NB_TIMEOUT-1:0] TIMEOUT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  state_t               state, state_next;
  logic [NB_DATA-1:0]   alu_a_next, alu_b_next, tx_data_next;
  logic [NB_OP-1:0]     alu_op_next;
  logic [NB_OP-1:0]     rx_op;
  logic [NB_TIMEOUT-1:0] timer, timer_next;
  logic                 op_valid;
  logic                 timed_out;
  logic                 error_next, overrun_next, tx_start_next, busy_next;

  assign rx_op     = i_rx_data[NB_OP-1:0];
  assign timed_out = (timer == TIMEOUT_LAST);

  always_comb begin
    op_valid = 1'b0;
    case (rx_op)
      NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100), NB_OP'(6'b100101),
      NB_OP'(6'b100110), NB_OP'(6'b100111), NB_OP'(6'b000011), NB_OP'(6'b000010):
        op_valid = 1'b1;
      default: op_valid = 1'b0;
    endcase
  end

  // A byte arriving on the same cycle as the timeout wins: the rx check comes first.
  always_comb begin
    state_next    = state;
    alu_a_next    = o_alu_a;
    alu_b_next    = o_alu_b;
    alu_op_next   = o_alu_op;
    tx_data_next  = o_tx_data;
    timer_next    = '0;
    error_next    = 1'b0;
    tx_start_next = 1'b0;
    case (state)
      WAIT_A: begin
        if (i_rx_done_tick) begin
          alu_a_next = i_rx_data;
          state_next = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_rx_done_tick) begin
          alu_b_next = i_rx_data;
          state_next = WAIT_OP;
        end else if (timed_out) begin
          error_next = 1'b1;
          state_next = WAIT_A;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      WAIT_OP: begin
        if (i_rx_done_tick) begin
          if (op_valid) begin
            alu_op_next = rx_op;
            state_next  = EXEC;
          end else begin
            error_next = 1'b1;
            state_next = WAIT_A;
          end
        end else if (timed_out) begin
          error_next = 1'b1;
          state_next = WAIT_A;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      EXEC: begin
        tx_data_next  = i_alu_result;
        tx_start_next = 1'b1;
        state_next    = SEND;
      end
      SEND: begin
        state_next = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_tx_done_tick) state_next = WAIT_A;
      end
      default: state_next = WAIT_A;
    endcase
  end

  assign overrun_next = i_rx_done_tick && (state inside {EXEC, SEND, WAIT_TX});
  assign busy_next    = state_next inside {EXEC, SEND, WAIT_TX};

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state      <= WAIT_A;
      timer      <= '0;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_error    <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      o_alu_a    <= alu_a_next;
      o_alu_b    <= alu_b_next;
      o_alu_op   <= alu_op_next;
      o_tx_data  <= tx_data_next;
      o_tx_start <= tx_start_next;
      o_busy     <= busy_next;
      o_error    <= error_next;
      o_overrun  <= overrun_next;
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: directed frames plus random frames, checked against a
// frame-level model of the sequencer and a behavioural ALU.
module tb_uart_alu_ctrl;

  localparam int TIMEOUT_CYCLES = 16;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_rx_done_tick = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_tx_done_tick = 1'b0;
  logic [7:0] i_alu_result;
  logic [7:0] o_alu_a, o_alu_b, o_tx_data;
  logic [5:0] o_alu_op;
  logic       o_tx_start, o_busy, o_error, o_overrun;

  int n_compared = 0;
  int n_mismatched = 0;
  int n_tx_start = 0, n_error = 0, n_overrun = 0;
  int exp_tx_start = 0, exp_error = 0, exp_overrun = 0;
  logic [5:0] model_op = 6'd0;
  logic prev_tx_start = 1'b0, prev_error = 1'b0, prev_overrun = 1'b0;

  uart_alu_ctrl #(
    .NB_DATA(8), .NB_OP(6), .NB_TIMEOUT(24), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_rx_done_tick(i_rx_done_tick), .i_rx_data(i_rx_data),
    .i_tx_done_tick(i_tx_done_tick), .i_alu_result(i_alu_result),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_busy(o_busy),
    .o_error(o_error), .o_overrun(o_overrun)
  );

  always #5 i_clock = ~i_clock;

  function automatic bit op_is_valid(input logic [5:0] op);
    logic [5:0] valid_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
    foreach (valid_ops[i]) if (valid_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return $unsigned($signed(a) >>> b);
      6'h02:   return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  assign i_alu_result = alu_model(o_alu_a, o_alu_b, o_alu_op);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    i_rx_data      = data;
    i_rx_done_tick = 1'b1;
    tick();
    i_rx_done_tick = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_a"},        o_alu_a, 0);
    checkOutput({tag, "_b"},        o_alu_b, 0);
    checkOutput({tag, "_op"},       o_alu_op, 0);
    checkOutput({tag, "_tx_start"}, o_tx_start, 0);
    checkOutput({tag, "_tx_data"},  o_tx_data, 0);
    checkOutput({tag, "_busy"},     o_busy, 0);
    checkOutput({tag, "_error"},    o_error, 0);
    checkOutput({tag, "_overrun"},  o_overrun, 0);
  endtask

  // Checks everything after the opcode byte has been delivered.
  task automatic finishFrame(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] opbyte, input bit do_overrun);
    logic [5:0] op;
    logic [7:0] exp;
    op = opbyte[5:0];
    checkOutput("frame_a", o_alu_a, a);
    checkOutput("frame_b", o_alu_b, b);
    if (op_is_valid(op)) begin
      exp = alu_model(a, b, op);
      model_op = op;
      checkOutput("op_latched", o_alu_op, op);
      checkOutput("busy_exec", o_busy, 1);
      checkOutput("no_start_exec", o_tx_start, 0);
      tick();
      checkOutput("tx_start", o_tx_start, 1);
      checkOutput("tx_data", o_tx_data, exp);
      exp_tx_start++;
      tick();
      checkOutput("tx_start_end", o_tx_start, 0);
      checkOutput("busy_wait_tx", o_busy, 1);
      repeat ($urandom_range(0, 4)) tick();
      if (do_overrun) begin
        applyStimulus(8'($urandom));
        exp_overrun++;
        checkOutput("overrun", o_overrun, 1);
        tick();
        checkOutput("overrun_end", o_overrun, 0);
        checkOutput("tx_data_hold", o_tx_data, exp);
        checkOutput("busy_after_ovr", o_busy, 1);
      end
      i_tx_done_tick = 1'b1;
      tick();
      i_tx_done_tick = 1'b0;
      checkOutput("busy_done", o_busy, 0);
    end else begin
      exp_error++;
      checkOutput("bad_op_error", o_error, 1);
      checkOutput("bad_op_busy", o_busy, 0);
      checkOutput("bad_op_keep", o_alu_op, model_op);
      tick();
      checkOutput("bad_op_error_end", o_error, 0);
      checkOutput("bad_op_no_start", o_tx_start, 0);
    end
  endtask

  task automatic runFrame(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] opbyte, input bit do_overrun);
    applyStimulus(a);
    applyStimulus(b);
    applyStimulus(opbyte);
    finishFrame(a, b, opbyte, do_overrun);
  endtask

  // Pulse-width and event counting on the falling edge.
  always @(negedge i_clock) begin
    if (o_tx_start) begin
      n_tx_start++;
      checkOutput("tx_start_width", prev_tx_start, 0);
    end
    if (o_error) begin
      n_error++;
      checkOutput("error_width", prev_error, 0);
    end
    if (o_overrun) begin
      n_overrun++;
      checkOutput("overrun_width", prev_overrun, 0);
    end
    prev_tx_start = o_tx_start;
    prev_error    = o_error;
    prev_overrun  = o_overrun;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] a, b, opbyte;
    repeat (3) tick();
    checkAllZero("reset");
    i_reset = 1'b1;
    tick();

    runFrame(8'h05, 8'h03, 8'h20, 1'b0);
    checkOutput("add_result", o_tx_data, 8'h08);
    runFrame(8'hF0, 8'h0F, 8'h22, 1'b0);
    runFrame(8'hF0, 8'h0F, 8'h22, 1'b0);
    checkOutput("sub_result", o_tx_data, 8'hE1);
    runFrame(8'h01, 8'h02, 8'h3F, 1'b0);
    runFrame(8'h81, 8'h01, 8'h03, 1'b0);
    checkOutput("sra_result", o_tx_data, 8'hC0);

    applyStimulus(8'hAA);
    repeat (TIMEOUT_CYCLES - 1) tick();
    checkOutput("timeout_early", o_error, 0);
    tick();
    checkOutput("timeout_error", o_error, 1);
    checkOutput("timeout_keep_a", o_alu_a, 8'hAA);
    checkOutput("timeout_idle", o_busy, 0);
    exp_error++;
    tick();
    runFrame(8'h11, 8'h22, 8'h20, 1'b0);
    checkOutput("after_timeout", o_tx_data, 8'h33);

    applyStimulus(8'h40);
    repeat (TIMEOUT_CYCLES - 1) tick();
    applyStimulus(8'h02);
    checkOutput("boundary_no_error", o_error, 0);
    applyStimulus(8'h22);
    finishFrame(8'h40, 8'h02, 8'h22, 1'b0);
    checkOutput("boundary_result", o_tx_data, 8'h3E);

    applyStimulus(8'h07);
    applyStimulus(8'h09);
    repeat (TIMEOUT_CYCLES) tick();
    checkOutput("timeout_op", o_error, 1);
    exp_error++;
    tick();

    runFrame(8'h3C, 8'h0F, 8'h26, 1'b1);
    runFrame(8'h12, 8'h34, 8'h25, 1'b0);
    checkOutput("after_overrun", o_tx_data, 8'h36);

    applyStimulus(8'h55);
    applyStimulus(8'h66);
    i_reset = 1'b0;
    i_rx_data = 8'h20;
    i_rx_done_tick = 1'b1;
    tick();
    i_rx_done_tick = 1'b0;
    checkAllZero("reset_wait_op");
    i_reset = 1'b1;
    model_op = 6'd0;
    repeat (4) tick();
    checkOutput("reset_wait_op_idle", o_busy, 0);

    applyStimulus(8'h21);
    applyStimulus(8'h12);
    applyStimulus(8'h24);
    repeat (3) tick();
    exp_tx_start++;
    checkOutput("pre_reset_busy", o_busy, 1);
    i_reset = 1'b0;
    tick();
    checkAllZero("reset_wait_tx");
    i_reset = 1'b1;
    model_op = 6'd0;
    repeat (3) tick();

    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom);
      b = 8'($urandom_range(0, 9));
      if ($urandom_range(0, 4) == 0)
        opbyte = 8'($urandom);
      else begin
        case ($urandom_range(0, 7))
          0: opbyte = 8'h20;
          1: opbyte = 8'h22;
          2: opbyte = 8'h24;
          3: opbyte = 8'h25;
          4: opbyte = 8'h26;
          5: opbyte = 8'h27;
          6: opbyte = 8'h03;
          default: opbyte = 8'h02;
        endcase
        opbyte[7:6] = 2'($urandom_range(0, 3));
      end
      runFrame(a, b, opbyte, $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    checkOutput("count_tx_start", n_tx_start, exp_tx_start);
    checkOutput("count_error", n_error, exp_error);
    checkOutput("count_overrun", n_overrun, exp_overrun);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
